// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive-side frame buffer.
// A frame is stored as {error, data}; the error counter saturates instead of wrapping.
package uart_pkg;

  localparam int ERR_CNT_W    = 16;
  localparam int FRAME_DATA_W = 8;

  typedef struct packed {
    logic                    error;
    logic [FRAME_DATA_W-1:0] data;
  } frame_t;

  // Stored entry width for a given payload width (payload plus error flag).
  function automatic int frame_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
    return (value == {ERR_CNT_W{1'b1}}) ? value : value + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Frame storage array: synchronous write port, asynchronous read port at the head pointer.
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Entries are not reset; validity is tracked by the controller's count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_frame_fifo.sv
// First-word-fall-through frame buffer behind the UART receiver, with occupancy flags,
// sticky overflow, optional discard of parity-errored frames and a saturating error counter.
module uart_rx_frame_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_error,
  input  logic                     drop_errored,
  input  logic                     stat_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_error,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = frame_w(DATA_WIDTH);

  logic          in_valid_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          we;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_evt;
  logic          err_evt;
  logic [FW-1:0] head;

  // The receiver strobe is edge-detected so a held-high valid yields one write.
  always_comb begin
    we          = in_valid & ~in_valid_q;
    push_req    = we & ~(drop_errored & in_error);
    pop         = out_valid & out_ready;
    full        = (count == CW'(DEPTH));
    almost_full = (count >= CW'(AFULL_LEVEL));
    push        = push_req & (~full | pop);
    ovf_evt     = push_req & full & ~pop;
    err_evt     = we & in_error;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end else begin
      count_nxt = count;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (FW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_data ({in_error, in_data}),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  assign out_error = head[FW-1];
  assign out_data  = head[DATA_WIDTH-1:0];

  // Pointer, occupancy and statistics state; a same-cycle event beats stat_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
    end else begin
      in_valid_q <= in_valid;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      out_valid <= (count_nxt != CW'(0));
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (stat_clr) begin
        overflow <= 1'b0;
      end
      if (stat_clr) begin
        err_count <= err_evt ? ERR_CNT_W'(1) : ERR_CNT_W'(0);
      end else if (err_evt) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench for uart_rx_frame_fifo; expected frames go into a queue that a negedge
// monitor pops and compares whenever the DUT hands over an entry.
module tb_uart_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_error;
  logic        drop_errored;
  logic        stat_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_error;
  logic [4:0]  count;
  logic        full;
  logic        almost_full;
  logic        overflow;
  logic [15:0] err_count;

  logic [8:0]  exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_frame_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_error     (in_error),
    .drop_errored (drop_errored),
    .stat_clr     (stat_clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_error    (out_error),
    .count        (count),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d, input logic e, input bit expect_stored);
    in_valid = 1'b1;
    in_data  = d;
    in_error = e;
    if (expect_stored) exp_q.push_back({e, d});
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && count != 5'd0; k++) tick();
    out_ready = 1'b0;
    check("drain_empty", {27'd0, count}, 32'd0);
  endtask

  // Monitor: every handshake visible at the negedge must match the next expected frame.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame: got %h expected none", {out_error, out_data});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({out_error, out_data} !== e) begin
          n_fail++;
          $display("FAIL frame: got %h expected %h", {out_error, out_data}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_error = 1'b0;
    drop_errored = 1'b0; stat_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_afull", {31'd0, almost_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_errcnt", {16'd0, err_count}, 32'd0);

    // Single frame, first-word-fall-through latency, then pop.
    in_valid = 1'b1; in_data = 8'hA5; in_error = 1'b0; exp_q.push_back(9'h0A5);
    tick();
    in_valid = 1'b0;
    check("a5_valid", {31'd0, out_valid}, 32'd1);
    check("a5_count", {27'd0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("a5_popped_count", {27'd0, count}, 32'd0);
    check("a5_popped_valid", {31'd0, out_valid}, 32'd0);

    // Held-high strobe stores one frame.
    in_valid = 1'b1; in_data = 8'h3C; exp_q.push_back(9'h03C);
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    check("held_count", {27'd0, count}, 32'd1);
    drain();

    // Fill to full, overflow, then drain across the pointer wrap.
    for (int i = 0; i < 16; i++) begin
      pulse(8'(i), 1'b0, 1'b1);
      if (i == 12) check("afull_13", {31'd0, almost_full}, 32'd0);
      if (i == 13) check("afull_14", {31'd0, almost_full}, 32'd1);
    end
    check("full_count", {27'd0, count}, 32'd16);
    check("full_flag", {31'd0, full}, 32'd1);
    check("no_ovf_yet", {31'd0, overflow}, 32'd0);
    pulse(8'hFF, 1'b0, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Push into a full FIFO alongside a pop.
    in_valid = 1'b1; in_data = 8'h77; in_error = 1'b0; out_ready = 1'b1;
    exp_q.push_back(9'h077);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_count", {27'd0, count}, 32'd16);
    check("pp_ovf", {31'd0, overflow}, 32'd0);
    tick();
    drain();

    // Errored-frame discard and error counting.
    drop_errored = 1'b1;
    pulse(8'h11, 1'b1, 1'b0);
    pulse(8'h22, 1'b0, 1'b1);
    pulse(8'h33, 1'b1, 1'b0);
    check("drop_count", {27'd0, count}, 32'd1);
    check("drop_errcnt", {16'd0, err_count}, 32'd2);
    drop_errored = 1'b0;
    pulse(8'h44, 1'b1, 1'b1);
    check("keep_count", {27'd0, count}, 32'd2);
    check("keep_errcnt", {16'd0, err_count}, 32'd3);
    drain();

    // stat_clr coinciding with an overflow and with an error event.
    for (int i = 0; i < 16; i++) pulse(8'h50 + 8'(i), 1'b0, 1'b1);
    stat_clr = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_error = 1'b0;
    tick();
    stat_clr = 1'b0; in_valid = 1'b0;
    check("clr_vs_ovf", {31'd0, overflow}, 32'd1);
    check("clr_errcnt", {16'd0, err_count}, 32'd0);
    tick();
    drop_errored = 1'b1;
    stat_clr = 1'b1; in_valid = 1'b1; in_data = 8'hEF; in_error = 1'b1;
    tick();
    stat_clr = 1'b0; in_valid = 1'b0;
    check("clr_vs_err", {16'd0, err_count}, 32'd1);
    check("clr_ovf_now", {31'd0, overflow}, 32'd0);
    tick();
    drain();

    // Saturation of the error counter from a preset value.
    @(negedge clk);
    force dut.err_count = 16'hFFFD;
    #1;
    release dut.err_count;
    tick();
    pulse(8'h01, 1'b1, 1'b0);
    check("sat_fffe", {16'd0, err_count}, 32'h0000FFFE);
    pulse(8'h02, 1'b1, 1'b0);
    check("sat_ffff", {16'd0, err_count}, 32'h0000FFFF);
    pulse(8'h03, 1'b1, 1'b0);
    check("sat_hold", {16'd0, err_count}, 32'h0000FFFF);
    drop_errored = 1'b0;

    // Reset mid-operation discards stored frames.
    pulse(8'h61, 1'b0, 1'b0);
    pulse(8'h62, 1'b0, 1'b0);
    check("pre_rst_count", {27'd0, count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", {27'd0, count}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_errcnt", {16'd0, err_count}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
